mult_acc: RTL and testbench
===========================

# mult_acc

Sequential shift-add multiplier-accumulator, the parametrised successor of the team's fixed-width sequential multiplier. It retires one multiplier bit per clock and latches operands and sign modes at start, so the upstream may change them while the block is busy. It adds a busy/start handshake and an optional wrap-around accumulator with a sticky overflow flag. It sits in the sensor datapath between the sample register and the filter and gain stages.

## Interface
Parameters:
- BW_MCAND, 8, multiplicand width (>= 2)
- BW_MLIER, 8, multiplier width (>= 2)
- BW_CNT, 4, counter width, ceiling(log2(BW_MLIER+1))
- BW_ACC, 20, accumulator width (>= BW_MCAND+BW_MLIER)

Ports:
- clk  in  1  clock, rising edge
- rstx  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; clears all state
- start  in  1  request; accepted only when busy=0
- mcand_is_signed  in  1  mcand is two's complement
- mlier_is_signed  in  1  mlier is two's complement
- accumulate  in  1  add this product into acc on completion
- mcand  in  BW_MCAND  multiplicand
- mlier  in  BW_MLIER  multiplier
- busy  out  1  operation in progress
- prod  out  BW_MCAND+BW_MLIER  exact product
- prod_valid  out  1  one-cycle completion pulse
- acc  out  BW_ACC  accumulator
- acc_valid  out  1  one-cycle pulse after acc update
- acc_ovf  out  1  sticky accumulator overflow

## Operation
- Every output and every internal register resets to 0.
- start is accepted when start=1 and busy=0.
- On acceptance, the block latches mcand, mlier, both sign modes and accumulate, and loads cnt with BW_MLIER.
- start while busy=1 is ignored.
- Operand or mode changes during busy do not affect the result.
- The block is in state BUSY while cnt != 0. It processes one multiplier bit per cycle and decrements cnt.
- On the last bit, when mlier is signed, the partial product is subtracted (sign-bit weight is negative).
- The result equals value(mcand)*value(mlier), exact in BW_MCAND+BW_MLIER bits.
- The product is two's complement if either operand is signed, otherwise unsigned.
- prod holds its value until the next accepted start, clear or reset. Intermediate shift contents on prod during busy are don't-care.
- Accumulate:
  - On the cycle after prod_valid, if the latched accumulate=1: acc <= acc + ext(prod) and acc_valid pulses.
  - ext() sign-extends prod if the product is signed, otherwise zero-extends.
  - acc wraps modulo 2^BW_ACC.
  - acc_ovf sets on signed overflow (signed product) or carry-out (unsigned product). It stays set until clear or reset.
  - With the latched accumulate=0, acc is untouched and acc_valid stays low.
- clear=1 has priority over start:
  - It aborts any operation and zeroes cnt, prod, acc and acc_ovf.
  - No prod_valid or acc_valid pulse follows for the aborted operation, including a pending acc update.
- rstx low mid-operation has the same effect as clear, but asynchronously.

## Timing
- Let N = BW_MLIER and let edge k sample the accepted start.
- busy is 1 after edges k..k+N-1 and falls at edge k+N.
- prod_valid rises at edge k+N, with prod final, for exactly one cycle.
- acc and acc_valid update at edge k+N+1.
- Back-to-back operation is legal:
  - start is accepted in the prod_valid cycle (busy=0 there).
  - A new operation costs N cycles.
  - The pending acc update of the previous operation still completes.
- No valid pulse is ever produced without an accepted start.

## Configuration
- MULT_ACC_EN defined:
  - The accumulator, acc_valid and acc_ovf logic is compiled in as described.
- MULT_ACC_EN undefined:
  - The accumulate input is ignored.
  - acc, acc_valid and acc_ovf are tied to 0.
  - The port list is unchanged.
  - Multiply timing is identical.

## Test plan
All cases use default parameters.
- Unsigned 0xFF*0xFF, start at edge k -> busy for 8 cycles, prod=0xFE01, prod_valid high only after edge k+8.
- Signed cases:
  - Signed*signed 0x80*0x80 -> prod=0x4000.
  - Signed 0xFF * signed 0x7F -> 0xFF81.
  - Unsigned 0xFF * signed 0xFF -> 0xFF01.
- Start 3*5, then while busy pulse start and change mcand/mlier/modes -> second start ignored, prod=0x000F.
- clear, then three back-to-back accumulate ops of 100*100 unsigned, each start in the previous prod_valid cycle -> acc=0x7530 after the third acc_valid, acc_ovf=0.
- Signed accumulate of 0x80*0x80 repeated 32 times -> acc=0x80000 (wrapped), acc_ovf=1. Then clear -> acc=0, acc_ovf=0.
- Start, then clear at cycle 4 of busy -> busy=0, prod=0, no prod_valid or acc_valid.
- Repeat the abort with rstx pulsed low instead of clear -> same result.
- Rebuild without MULT_ACC_EN and repeat the accumulate test -> acc=0, acc_valid=0, prod values unchanged.

Source files
------------

// File: rtl/mult_acc_if.sv
// Handshake and data bundle for the mult_acc shift-add multiplier-accumulator.
// The master drives the requests and operands; the slave returns the status, the product and the accumulator.
interface mult_acc_if #(
    parameter int BW_MCAND = 8,
    parameter int BW_MLIER = 8,
    parameter int BW_ACC   = 20
);
    logic                         clear;
    logic                         start;
    logic                         mcand_is_signed;
    logic                         mlier_is_signed;
    logic                         accumulate;
    logic [BW_MCAND-1:0]          mcand;
    logic [BW_MLIER-1:0]          mlier;
    logic                         busy;
    logic [BW_MCAND+BW_MLIER-1:0] prod;
    logic                         prod_valid;
    logic [BW_ACC-1:0]            acc;
    logic                         acc_valid;
    logic                         acc_ovf;

    modport master (
        output clear, start, mcand_is_signed, mlier_is_signed, accumulate, mcand, mlier,
        input  busy, prod, prod_valid, acc, acc_valid, acc_ovf
    );

    modport slave (
        input  clear, start, mcand_is_signed, mlier_is_signed, accumulate, mcand, mlier,
        output busy, prod, prod_valid, acc, acc_valid, acc_ovf
    );
endinterface

// File: rtl/mult_acc.sv
// Sequential shift-add multiplier (one multiplier bit per clock) with an optional wrapping accumulator.
// Define MULT_ACC_EN to build the accumulator; without it acc, acc_valid and acc_ovf are tied low.
module mult_acc #(
    parameter int BW_MCAND = 8,
    parameter int BW_MLIER = 8,
    parameter int BW_CNT   = 4,
    parameter int BW_ACC   = 20
) (
    input  logic       clk,
    input  logic       rstx,
    mult_acc_if.slave  bus
);
    localparam int BW_PROD = BW_MCAND + BW_MLIER;

    logic [BW_CNT-1:0]   cnt_reg, cnt_next;
    logic [BW_PROD-1:0]  mcand_sh_reg, mcand_sh_next;
    logic [BW_MLIER-1:0] mlier_sh_reg, mlier_sh_next;
    logic [BW_PROD-1:0]  prod_reg, prod_next;
    logic                mlier_signed_reg, mlier_signed_next;
    logic                prod_valid_reg, prod_valid_next;
    logic [BW_PROD-1:0]  mcand_ext;
    logic                busy;
    logic                accept;
    logic                last_bit;

    assign busy     = (cnt_reg != '0);
    assign accept   = bus.start & ~busy & ~bus.clear;
    assign last_bit = (cnt_reg == BW_CNT'(1));

    // Multiplicand widened once at start so every shifted partial product is already in product width.
    assign mcand_ext[BW_MCAND-1:0] = bus.mcand;
    genvar gi;
    generate
        for (gi = BW_MCAND; gi < BW_PROD; gi++) begin : g_mcand_ext
            assign mcand_ext[gi] = bus.mcand_is_signed & bus.mcand[BW_MCAND-1];
        end
    endgenerate

    always_comb begin
        cnt_next          = cnt_reg;
        mcand_sh_next     = mcand_sh_reg;
        mlier_sh_next     = mlier_sh_reg;
        prod_next         = prod_reg;
        mlier_signed_next = mlier_signed_reg;
        prod_valid_next   = 1'b0;
        if (bus.clear) begin
            cnt_next          = '0;
            mcand_sh_next     = '0;
            mlier_sh_next     = '0;
            prod_next         = '0;
            mlier_signed_next = 1'b0;
        end else if (accept) begin
            cnt_next          = BW_CNT'(BW_MLIER);
            mcand_sh_next     = mcand_ext;
            mlier_sh_next     = bus.mlier;
            prod_next         = '0;
            mlier_signed_next = bus.mlier_is_signed;
        end else if (busy) begin
            cnt_next      = cnt_reg - BW_CNT'(1);
            mcand_sh_next = mcand_sh_reg << 1;
            mlier_sh_next = mlier_sh_reg >> 1;
            // The sign bit of a signed multiplier carries negative weight.
            if (mlier_sh_reg[0]) begin
                if (last_bit && mlier_signed_reg)
                    prod_next = prod_reg - mcand_sh_reg;
                else
                    prod_next = prod_reg + mcand_sh_reg;
            end
            prod_valid_next = last_bit;
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            cnt_reg          <= '0;
            mcand_sh_reg     <= '0;
            mlier_sh_reg     <= '0;
            prod_reg         <= '0;
            mlier_signed_reg <= 1'b0;
            prod_valid_reg   <= 1'b0;
        end else begin
            cnt_reg          <= cnt_next;
            mcand_sh_reg     <= mcand_sh_next;
            mlier_sh_reg     <= mlier_sh_next;
            prod_reg         <= prod_next;
            mlier_signed_reg <= mlier_signed_next;
            prod_valid_reg   <= prod_valid_next;
        end
    end

    assign bus.busy       = busy;
    assign bus.prod       = prod_reg;
    assign bus.prod_valid = prod_valid_reg;

`ifdef MULT_ACC_EN
    logic              acc_en_reg, acc_en_next;
    logic              prod_signed_reg, prod_signed_next;
    logic [BW_ACC-1:0] acc_reg, acc_next;
    logic              acc_valid_reg, acc_valid_next;
    logic              acc_ovf_reg, acc_ovf_next;
    logic [BW_ACC-1:0] prod_ext;
    logic [BW_ACC:0]   acc_sum;
    logic              acc_ovf_hit;

    assign prod_ext[BW_PROD-1:0] = prod_reg;
    generate
        for (gi = BW_PROD; gi < BW_ACC; gi++) begin : g_prod_ext
            assign prod_ext[gi] = prod_signed_reg & prod_reg[BW_PROD-1];
        end
    endgenerate

    assign acc_sum     = {1'b0, acc_reg} + {1'b0, prod_ext};
    assign acc_ovf_hit = prod_signed_reg
                       ? ((acc_reg[BW_ACC-1] == prod_ext[BW_ACC-1]) && (acc_sum[BW_ACC-1] != acc_reg[BW_ACC-1]))
                       : acc_sum[BW_ACC];

    // The update uses the modes latched for the finished product, even if a new start lands on the same edge.
    always_comb begin
        acc_en_next      = acc_en_reg;
        prod_signed_next = prod_signed_reg;
        acc_next         = acc_reg;
        acc_valid_next   = 1'b0;
        acc_ovf_next     = acc_ovf_reg;
        if (bus.clear) begin
            acc_en_next      = 1'b0;
            prod_signed_next = 1'b0;
            acc_next         = '0;
            acc_ovf_next     = 1'b0;
        end else begin
            if (accept) begin
                acc_en_next      = bus.accumulate;
                prod_signed_next = bus.mcand_is_signed | bus.mlier_is_signed;
            end
            if (prod_valid_reg && acc_en_reg) begin
                acc_next       = acc_sum[BW_ACC-1:0];
                acc_valid_next = 1'b1;
                acc_ovf_next   = acc_ovf_reg | acc_ovf_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            acc_en_reg      <= 1'b0;
            prod_signed_reg <= 1'b0;
            acc_reg         <= '0;
            acc_valid_reg   <= 1'b0;
            acc_ovf_reg     <= 1'b0;
        end else begin
            acc_en_reg      <= acc_en_next;
            prod_signed_reg <= prod_signed_next;
            acc_reg         <= acc_next;
            acc_valid_reg   <= acc_valid_next;
            acc_ovf_reg     <= acc_ovf_next;
        end
    end

    assign bus.acc       = acc_reg;
    assign bus.acc_valid = acc_valid_reg;
    assign bus.acc_ovf   = acc_ovf_reg;
`else
    logic unused_accumulate;
    assign unused_accumulate = bus.accumulate;
    assign bus.acc       = '0;
    assign bus.acc_valid = 1'b0;
    assign bus.acc_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_mult_acc.sv
// Directed bench for mult_acc: multiply timing, sign modes, busy handling, accumulation, abort paths.
// Accumulator expectations follow MULT_ACC_EN so the same bench covers both builds.
module tb_mult_acc;
    localparam int BW_MCAND = 8;
    localparam int BW_MLIER = 8;
    localparam int BW_CNT   = 4;
    localparam int BW_ACC   = 20;
`ifdef MULT_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstx = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mult_acc_if #(.BW_MCAND(BW_MCAND), .BW_MLIER(BW_MLIER), .BW_ACC(BW_ACC)) bus ();

    mult_acc #(
        .BW_MCAND(BW_MCAND),
        .BW_MLIER(BW_MLIER),
        .BW_CNT  (BW_CNT),
        .BW_ACC  (BW_ACC)
    ) dut (
        .clk (clk),
        .rstx(rstx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns just after the accepting edge.
    task automatic do_start(input bit ms, input bit ls, input bit acc_e,
                            input logic [7:0] a, input logic [7:0] b);
        bus.mcand_is_signed = ms;
        bus.mlier_is_signed = ls;
        bus.accumulate      = acc_e;
        bus.mcand           = a;
        bus.mlier           = b;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        $display("op mcand=%h(s=%0d) mlier=%h(s=%0d) accumulate=%0d", a, ms, b, ls, acc_e);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.prod_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 20) begin errors++; $display("FAIL done_timeout got=no prod_valid exp=prod_valid within 20 cycles"); end
    endtask

    task automatic clear_pulse();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        bus.clear = 0; bus.start = 0; bus.mcand_is_signed = 0; bus.mlier_is_signed = 0;
        bus.accumulate = 0; bus.mcand = '0; bus.mlier = '0;
        rstx = 1'b0;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.prod !== 16'h0) begin errors++; $display("FAIL reset_prod got=%h exp=0000", bus.prod); end
        checks++; if (bus.prod_valid !== 1'b0) begin errors++; $display("FAIL reset_prod_valid got=%b exp=0", bus.prod_valid); end
        checks++; if (bus.acc !== 20'h0) begin errors++; $display("FAIL reset_acc got=%h exp=00000", bus.acc); end
        checks++; if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid got=%b exp=0", bus.acc_valid); end
        checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL reset_acc_ovf got=%b exp=0", bus.acc_ovf); end
        #3 rstx = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_unsigned_timing();
        do_start(0, 0, 0, 8'hFF, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.busy !== 1'b1 || bus.prod_valid !== 1'b0) begin
                errors++; $display("FAIL busy_window edge=k+%0d got busy=%b pv=%b exp busy=1 pv=0", i, bus.busy, bus.prod_valid);
            end
            tick();
        end
        checks++; if (bus.busy !== 1'b0 || bus.prod_valid !== 1'b1) begin
            errors++; $display("FAIL done_edge got busy=%b pv=%b exp busy=0 pv=1", bus.busy, bus.prod_valid);
        end
        checks++; if (bus.prod !== 16'hFE01) begin errors++; $display("FAIL prod_ff_ff got=%h exp=fe01", bus.prod); end
        tick();
        checks++; if (bus.prod_valid !== 1'b0) begin errors++; $display("FAIL pv_one_cycle got=%b exp=0", bus.prod_valid); end
        checks++; if (bus.prod !== 16'hFE01) begin errors++; $display("FAIL prod_hold got=%h exp=fe01", bus.prod); end
    endtask

    task automatic test_signed();
        bit          tms [3] = '{1'b1, 1'b1, 1'b0};
        bit          tls [3] = '{1'b1, 1'b1, 1'b1};
        logic [7:0]  ta  [3] = '{8'h80, 8'hFF, 8'hFF};
        logic [7:0]  tb  [3] = '{8'h80, 8'h7F, 8'hFF};
        logic [15:0] te  [3] = '{16'h4000, 16'hFF81, 16'hFF01};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            do_start(tms[i], tls[i], 0, ta[i], tb[i]);
            wait_done(cyc);
            checks++; if (cyc != 8) begin errors++; $display("FAIL signed_latency[%0d] got=%0d exp=8", i, cyc); end
            checks++; if (bus.prod !== te[i]) begin errors++; $display("FAIL signed_prod[%0d] got=%h exp=%h", i, bus.prod, te[i]); end
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        do_start(0, 0, 0, 8'd3, 8'd5);
        tick();
        bus.mcand = 8'hAA; bus.mlier = 8'h55;
        bus.mcand_is_signed = 1; bus.mlier_is_signed = 1; bus.accumulate = 1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc);
        checks++; if (cyc != 6) begin errors++; $display("FAIL ignore_latency got=%0d exp=6", cyc); end
        checks++; if (bus.prod !== 16'h000F) begin errors++; $display("FAIL ignore_prod got=%h exp=000f", bus.prod); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got=%b exp=0", bus.busy); end
        checks++; if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL ignore_acc_valid got=%b exp=0", bus.acc_valid); end
        checks++; if (bus.acc !== 20'h0) begin errors++; $display("FAIL ignore_acc got=%h exp=00000", bus.acc); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [19:0] exp_acc;
        clear_pulse();
        checks++; if (bus.acc !== 20'h0) begin errors++; $display("FAIL b2b_clear_acc got=%h exp=00000", bus.acc); end
        do_start(0, 0, 1, 8'd100, 8'd100);
        wait_done(cyc);
        for (int j = 1; j <= 2; j++) begin
            do_start(0, 0, 1, 8'd100, 8'd100);
            exp_acc = ACC_ON ? 20'(j * 10000) : 20'h0;
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] got=%b exp=1", j, bus.busy); end
            checks++; if (bus.acc_valid !== ACC_ON) begin errors++; $display("FAIL b2b_acc_valid[%0d] got=%b exp=%b", j, bus.acc_valid, ACC_ON); end
            checks++; if (bus.acc !== exp_acc) begin errors++; $display("FAIL b2b_acc[%0d] got=%h exp=%h", j, bus.acc, exp_acc); end
            wait_done(cyc);
            checks++; if (cyc != 8) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=8", j, cyc); end
            checks++; if (bus.prod !== 16'h2710) begin errors++; $display("FAIL b2b_prod[%0d] got=%h exp=2710", j, bus.prod); end
        end
        tick();
        exp_acc = ACC_ON ? 20'h07530 : 20'h0;
        checks++; if (bus.acc_valid !== ACC_ON) begin errors++; $display("FAIL b2b_last_valid got=%b exp=%b", bus.acc_valid, ACC_ON); end
        checks++; if (bus.acc !== exp_acc) begin errors++; $display("FAIL b2b_total got=%h exp=%h", bus.acc, exp_acc); end
        checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", bus.acc_ovf); end
        tick();
        checks++; if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_pulse got=%b exp=0", bus.acc_valid); end
    endtask

    task automatic test_signed_wrap();
        int cyc;
        logic [19:0] exp_acc;
        clear_pulse();
        for (int i = 0; i < 33; i++) begin
            do_start(1, 1, 1, 8'h80, 8'h80);
            wait_done(cyc);
            tick();
            if (i == 30) begin
                exp_acc = ACC_ON ? 20'h7C000 : 20'h0;
                checks++; if (bus.acc !== exp_acc) begin errors++; $display("FAIL wrap_acc31 got=%h exp=%h", bus.acc, exp_acc); end
                checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf31 got=%b exp=0", bus.acc_ovf); end
            end
            if (i == 31) begin
                exp_acc = ACC_ON ? 20'h80000 : 20'h0;
                checks++; if (bus.acc !== exp_acc) begin errors++; $display("FAIL wrap_acc32 got=%h exp=%h", bus.acc, exp_acc); end
                checks++; if (bus.acc_ovf !== ACC_ON) begin errors++; $display("FAIL wrap_ovf32 got=%b exp=%b", bus.acc_ovf, ACC_ON); end
            end
        end
        exp_acc = ACC_ON ? 20'h84000 : 20'h0;
        checks++; if (bus.acc !== exp_acc) begin errors++; $display("FAIL wrap_acc33 got=%h exp=%h", bus.acc, exp_acc); end
        checks++; if (bus.acc_ovf !== ACC_ON) begin errors++; $display("FAIL wrap_ovf_sticky got=%b exp=%b", bus.acc_ovf, ACC_ON); end
        clear_pulse();
        checks++; if (bus.acc !== 20'h0) begin errors++; $display("FAIL wrap_clear_acc got=%h exp=00000", bus.acc); end
        checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL wrap_clear_ovf got=%b exp=0", bus.acc_ovf); end
    endtask

    task automatic test_abort_clear();
        int cyc;
        int pulses;
        do_start(0, 0, 1, 8'hFF, 8'hFF);
        tick(); tick(); tick();
        clear_pulse();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.prod !== 16'h0) begin errors++; $display("FAIL clr_prod got=%h exp=0000", bus.prod); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.prod_valid === 1'b1 || bus.acc_valid === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL clr_no_pulse got=%0d exp=0", pulses); end
        // Abort landing on the pending accumulator update.
        do_start(0, 0, 1, 8'd100, 8'd100);
        wait_done(cyc);
        clear_pulse();
        checks++; if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL clr_pending_valid got=%b exp=0", bus.acc_valid); end
        checks++; if (bus.acc !== 20'h0) begin errors++; $display("FAIL clr_pending_acc got=%h exp=00000", bus.acc); end
        checks++; if (bus.prod !== 16'h0) begin errors++; $display("FAIL clr_pending_prod got=%h exp=0000", bus.prod); end
    endtask

    task automatic test_abort_reset();
        int pulses;
        do_start(0, 0, 1, 8'hFF, 8'hFF);
        tick(); tick(); tick();
        #2 rstx = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.prod !== 16'h0) begin errors++; $display("FAIL rst_async_prod got=%h exp=0000", bus.prod); end
        #2 rstx = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.prod_valid === 1'b1 || bus.acc_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_no_pulse got=%0d exp=0", pulses); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%b exp=0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_unsigned_timing();
        test_signed();
        test_busy_ignore();
        test_back_to_back();
        test_signed_wrap();
        test_abort_clear();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
